// File: rtl/zoh_interp.sv
// First-order-hold reconstruction: ramps linearly from the previous held sample
// to the current one over N = 2^shift cycles, driven by the ZOH tick strobe.
module zoh_interp #(
   parameter int DW      = 16,
   parameter int SHIFT_W = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [SHIFT_W-1:0] shift,
   input  logic               tick,
   input  logic [DW-1:0]      sample_in,
   output logic [DW-1:0]      sample_out,
   output logic               out_valid,
   output logic               overrun
);
   localparam int SMAX = (1 << SHIFT_W) - 1;
   localparam int AW   = DW + 1 + SMAX;
   localparam int KW   = SMAX + 1;

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      PRIMED = 2'd1,
      RAMP   = 2'd2,
      HOLD   = 2'd3
   } state_t;

   state_t               state_r;
   state_t               state_s;
   logic [DW-1:0]        s_prev_r;
   logic [DW-1:0]        s_cur_r;
   logic [DW:0]          delta_r;
   logic signed [AW-1:0] acc_r;
   logic [KW-1:0]        k_r;
   logic [SHIFT_W-1:0]   shift_r;

   logic                 start_s;
   logic                 k_last_s;
   logic [DW:0]          delta_new_s;
   logic signed [AW-1:0] acc_next_s;
   logic [DW-1:0]        base_s;
   logic [SHIFT_W-1:0]   sh_s;
   logic [DW-1:0]        out_next_s;

   assign start_s     = tick && (state_r != EMPTY);
   assign delta_new_s = {sample_in[DW-1], sample_in} - {s_cur_r[DW-1], s_cur_r};
   assign k_last_s    = (k_r + KW'(1)) == (KW'(1) << shift_r);

   // Accumulator replaces k*delta; a tick restarts it from the fresh delta.
   always_comb begin
      acc_next_s = acc_r;
      base_s     = s_prev_r;
      sh_s       = shift_r;
      if (start_s) begin
         acc_next_s = {{(AW-DW-1){delta_new_s[DW]}}, delta_new_s};
         base_s     = s_cur_r;
         sh_s       = shift;
      end else begin
         acc_next_s = acc_r + {{(AW-DW-1){delta_r[DW]}}, delta_r};
         base_s     = s_prev_r;
         sh_s       = shift_r;
      end
      out_next_s = base_s + DW'(acc_next_s >>> sh_s);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= EMPTY;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; N = 1 skips straight to HOLD.
   always_comb begin
      state_s = state_r;
      case (state_r)
         EMPTY: begin
            if (tick) state_s = PRIMED;
            else      state_s = EMPTY;
         end
         PRIMED, HOLD: begin
            if (tick) state_s = (shift == '0) ? HOLD : RAMP;
            else      state_s = state_r;
         end
         RAMP: begin
            if (tick)          state_s = (shift == '0) ? HOLD : RAMP;
            else if (k_last_s) state_s = HOLD;
            else               state_s = RAMP;
         end
         default: state_s = EMPTY;
      endcase
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         s_prev_r   <= '0;
         s_cur_r    <= '0;
         delta_r    <= '0;
         acc_r      <= '0;
         k_r        <= '0;
         shift_r    <= '0;
         sample_out <= '0;
         out_valid  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         case (state_r)
            EMPTY: begin
               if (tick) begin
                  s_cur_r <= sample_in;
                  shift_r <= shift;
               end
            end
            PRIMED, RAMP, HOLD: begin
               if (tick) begin
                  s_prev_r   <= s_cur_r;
                  s_cur_r    <= sample_in;
                  delta_r    <= delta_new_s;
                  acc_r      <= acc_next_s;
                  k_r        <= KW'(1);
                  shift_r    <= shift;
                  sample_out <= out_next_s;
                  out_valid  <= 1'b1;
                  if (state_r == RAMP) overrun <= 1'b1;
               end else if (state_r == RAMP) begin
                  acc_r      <= acc_next_s;
                  k_r        <= k_r + KW'(1);
                  sample_out <= out_next_s;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
